pipelined_shift_unit: RTL and testbench
=======================================

Name: pipelined_shift_unit

Overview:
- Parametrised, fully pipelined barrel shifter for the RISC datapath ALU. Successor to the 32-bit combinational shifter.
- Supports logical-left, logical-right and arithmetic-right shifts at any power-of-two width, with full-width shift amounts.
- One operation issues per cycle behind a valid/ready handshake. Global stall under backpressure.
- A caller tag travels with each operation so the issue logic can match results.

Parameters:
- WIDTH, 32: data width. Power of two, 8..64.
- SHAMT_W, 32: width of the shift-amount input. Only the full value is meaningful (no truncation).
- TAG_W, 4: width of the sideband tag carried alongside each operation.
- Derived localparam LOG2W = clog2(WIDTH): number of pipeline stages and the latency.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation present on inputs.
- in_ready  out  1  unit accepts the operation this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHAMT_W  unsigned shift amount.
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (see Optional Feature).
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted result.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset (async, rst=1): all stage valid bits, data, tag and op registers clear to 0. Therefore out_valid=0, out_data=0, out_tag=0, and in_ready=1 after reset deasserts.
- Reset mid-operation flushes every in-flight operation. Nothing is replayed.

Pipeline:
- LOG2W register stages. Stage k (k=0..LOG2W-1) applies a shift of 2^k when bit k of the effective amount is set.
- Effective amount, op, fill bit and tag travel with the data.

Handshake and timing:
- stall = out_valid & ~out_ready.
- in_ready = ~stall.
- Acceptance happens when in_valid & in_ready.
- With no stall, the result appears exactly LOG2W cycles after acceptance (5 for WIDTH=32).
- Throughput is 1 operation per cycle.
- During a stall, all stages hold: data, valid and tag are frozen and out_data is stable.
- Bubbles (in_valid=0) propagate as valid=0 stages. No compaction.
- When stall falls and in_valid is high in the same cycle, the operation is accepted that cycle.

Arithmetic rules (decoded at acceptance):
- SLL: zero fill.
- SRL: zero fill.
- SRA: fill with in_data[WIDTH-1].
- Saturation: if in_shamt >= WIDTH, SLL and SRL give 0, and SRA gives all copies of the sign bit. This is implemented by forcing the data operand to the fill pattern at stage-0 entry.
- in_shamt = 0 passes the operand unchanged.
- The output is always exactly WIDTH bits. Shifted-out bits are discarded.
- No combinational path from in_* to out_*.

Optional Feature:
- Macro: PIPELINED_SHIFT_ROTATE_EN.
- Defined: in_op=11 performs rotate-right by (in_shamt mod WIDTH). No saturation applies, and bits shifted out re-enter at the MSB.
- Undefined: in_op=11 executes exactly as SRL (01), including saturation. No rotate muxing is synthesised.

Decomposition:
- Shared package shift_pkg holds:
  - op encoding constants SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b10, SHIFT_ROR=2'b11;
  - a stage-payload typedef {valid, op, fill, amt[LOG2W-1:0], tag, data}.
- One natural sub-module: shift_stage, instantiated LOG2W times via generate. Parameters are STAGE index k and WIDTH. It contains one conditional 2^k shift/rotate and its enable-gated register.

Test Plan:
1. Reset then idle. in_data=0xE2641233, op=SLL, shamt=4, out_ready=1 -> out_valid pulses exactly 5 cycles later, out_data=0x26412330, out_tag echoes in_tag.
2. Back-to-back, one per cycle: SRL 4, SRA 4, SRL 1256, SRA 1256, SLL 1256 on 0xE2641233 -> in order, on consecutive cycles: 0x0E264123, 0xFE264123, 0x00000000, 0xFFFFFFFF, 0x00000000.
3. Backpressure: stream 8 ops with tags 0..7 and drop out_ready for 3 cycles mid-stream -> in_ready low for exactly those stall cycles, out_data/out_tag held constant, all 8 tags emerge in order with no loss or duplication.
4. Rotate with macro defined: op=ROR on 0xE2641233 with shamt=4 -> 0x3E264123; with shamt=1256 -> 0x33E26412. Without the macro the same stimulus yields 0x0E264123 and 0x00000000.
5. Async reset asserted mid-flight with 3 ops in pipe -> out_valid drops immediately (no clock edge needed), no stale result after release, and the next op completes with correct latency.
6. Boundary amounts with shamt 0, 31, 32: SRA on 0x80000000 -> 0x80000000, 0xFFFFFFFF, 0xFFFFFFFF; SLL on 0x00000001 with shamt=31 -> 0x80000000.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared op encodings and per-stage control payload for the pipelined shifter.
// Width-dependent payload fields (amt, tag, data) travel beside this struct on parameterised ports.
package shift_pkg;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  typedef struct packed {
    logic       valid;
    logic [1:0] op;
    logic       fill;
  } stageCtrl_t;

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: conditional shift/rotate by 2^STAGE, registered when en is high.
// Latency 1 cycle; en low (global stall) freezes the whole stage payload.
module shift_stage
  import shift_pkg::*;
#(
  parameter int STAGE = 0,
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  localparam int LOG2W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  stageCtrl_t       ctrlIn,
  input  logic [LOG2W-1:0] amtIn,
  input  logic [TAG_W-1:0] tagIn,
  input  logic [WIDTH-1:0] dataIn,
  output stageCtrl_t       ctrlOut,
  output logic [LOG2W-1:0] amtOut,
  output logic [TAG_W-1:0] tagOut,
  output logic [WIDTH-1:0] dataOut
);

  localparam int SH = 1 << STAGE;

  logic [WIDTH-1:0] shifted;

  // Right shifts share one path; the fill bit already encodes SRL (0) versus SRA (sign).
  always_comb begin
    shifted = dataIn;
    if (amtIn[STAGE]) begin
      if (ctrlIn.op == SHIFT_SLL) begin
        shifted = {dataIn[WIDTH-1-SH:0], {SH{1'b0}}};
      end
`ifdef PIPELINED_SHIFT_ROTATE_EN
      else if (ctrlIn.op == SHIFT_ROR) begin
        shifted = {dataIn[SH-1:0], dataIn[WIDTH-1:SH]};
      end
`endif
      else begin
        shifted = {{SH{ctrlIn.fill}}, dataIn[WIDTH-1:SH]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrlOut <= '0;
      amtOut  <= '0;
      tagOut  <= '0;
      dataOut <= '0;
    end else if (en) begin
      ctrlOut <= ctrlIn;
      amtOut  <= amtIn;
      tagOut  <= tagIn;
      dataOut <= shifted;
    end
  end

endmodule

// File: rtl/pipelined_shift_unit.sv
// LOG2W-stage barrel shifter (SLL/SRL/SRA; ROR when PIPELINED_SHIFT_ROTATE_EN is defined).
// Latency LOG2W cycles, 1 op/cycle; every stage holds while out_valid & ~out_ready.
module pipelined_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 32,
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int LOG2W = $clog2(WIDTH);

  // Index 0 is the decoded entry payload, index k+1 is the output register of stage k.
  stageCtrl_t       ctrlS [LOG2W+1];
  logic [LOG2W-1:0] amtS  [LOG2W+1];
  logic [TAG_W-1:0] tagS  [LOG2W+1];
  logic [WIDTH-1:0] dataS [LOG2W+1];

  logic             stall;
  logic             shamtBig;
  logic             isRot;
  logic             saturate;
  logic             fillBit;
  logic [1:0]       opEff;
  stageCtrl_t       ctrl0;
  logic [LOG2W-1:0] amt0;
  logic [WIDTH-1:0] data0;

  assign stall    = ctrlS[LOG2W].valid & ~out_ready;
  assign in_ready = ~stall;
  assign shamtBig = (in_shamt >= SHAMT_W'(WIDTH));

  always_comb begin
    opEff = in_op;
    isRot = 1'b0;
`ifdef PIPELINED_SHIFT_ROTATE_EN
    isRot = (in_op == SHIFT_ROR);
`else
    if (in_op == SHIFT_ROR) begin
      opEff = SHIFT_SRL;
    end
`endif
    fillBit  = (opEff == SHIFT_SRA) & in_data[WIDTH-1];
    // Oversized shifts collapse to the fill pattern up front; later stages then leave it intact.
    saturate = shamtBig & ~isRot;
    ctrl0    = '{valid: in_valid, op: opEff, fill: fillBit};
    amt0     = saturate ? '0 : in_shamt[LOG2W-1:0];
    data0    = saturate ? {WIDTH{fillBit}} : in_data;
  end

  assign ctrlS[0] = ctrl0;
  assign amtS[0]  = amt0;
  assign tagS[0]  = in_tag;
  assign dataS[0] = data0;

  for (genvar k = 0; k < LOG2W; k++) begin : gStage
    shift_stage #(
      .STAGE (k),
      .WIDTH (WIDTH),
      .TAG_W (TAG_W)
    ) uStage (
      .clk     (clk),
      .rst     (rst),
      .en      (~stall),
      .ctrlIn  (ctrlS[k]),
      .amtIn   (amtS[k]),
      .tagIn   (tagS[k]),
      .dataIn  (dataS[k]),
      .ctrlOut (ctrlS[k+1]),
      .amtOut  (amtS[k+1]),
      .tagOut  (tagS[k+1]),
      .dataOut (dataS[k+1])
    );
  end

  assign out_valid = ctrlS[LOG2W].valid;
  assign out_data  = dataS[LOG2W];
  assign out_tag   = tagS[LOG2W];

  logic unusedTail;
  assign unusedTail = ^{ctrlS[LOG2W].op, ctrlS[LOG2W].fill, amtS[LOG2W]};

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Directed bench for pipelined_shift_unit at WIDTH=32 (5-cycle latency).
module tb_pipelined_shift_unit;
  import shift_pkg::*;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 32;
  localparam int TAG_W   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_op;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [TAG_W-1:0]   out_tag;

  always #5 clk = ~clk;

  pipelined_shift_unit #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W),
    .TAG_W   (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  logic [WIDTH-1:0] qData [$];
  logic [TAG_W-1:0] qTag  [$];
  int               qCyc  [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      qData.push_back(out_data);
      qTag.push_back(out_tag);
      qCyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] d, input logic [31:0] s,
                       input logic [3:0] t);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_shamt = s;
    in_tag   = t;
  endtask

  task automatic clearQ();
    qData.delete();
    qTag.delete();
    qCyc.delete();
  endtask

  function automatic logic [WIDTH-1:0] getD(input int i);
    return (qData.size() > i) ? qData[i] : 'x;
  endfunction

  function automatic logic [TAG_W-1:0] getT(input int i);
    return (qTag.size() > i) ? qTag[i] : 'x;
  endfunction

  function automatic int getC(input int i);
    return (qCyc.size() > i) ? qCyc[i] : -1000;
  endfunction

  int issueCyc;
  int idx;
  int readyBad;
  logic acc;
  logic [WIDTH-1:0] exp2 [5];
  logic [WIDTH-1:0] exp6 [4];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = SHIFT_SLL;
    in_tag = '0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_out_tag", 64'(out_tag), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // Single SLL: pulse exactly once, LOG2W cycles after issue
    clearQ();
    drive(SHIFT_SLL, 32'hE2641233, 32'd4, 4'd5);
    issueCyc = cyc;
    step();
    in_valid = 1'b0;
    repeat (8) step();
    check("t1_count", 64'(qData.size()), 64'd1);
    check("t1_data", 64'(getD(0)), 64'h26412330);
    check("t1_tag", 64'(getT(0)), 64'd5);
    check("t1_latency", 64'(getC(0) - issueCyc), 64'd5);

    // Back-to-back mix incl. saturating amounts
    clearQ();
    exp2[0] = 32'h0E264123; exp2[1] = 32'hFE264123; exp2[2] = 32'h00000000;
    exp2[3] = 32'hFFFFFFFF; exp2[4] = 32'h00000000;
    issueCyc = cyc;
    drive(SHIFT_SRL, 32'hE2641233, 32'd4, 4'd1);    step();
    drive(SHIFT_SRA, 32'hE2641233, 32'd4, 4'd2);    step();
    drive(SHIFT_SRL, 32'hE2641233, 32'd1256, 4'd3); step();
    drive(SHIFT_SRA, 32'hE2641233, 32'd1256, 4'd4); step();
    drive(SHIFT_SLL, 32'hE2641233, 32'd1256, 4'd5); step();
    in_valid = 1'b0;
    repeat (10) step();
    check("t2_count", 64'(qData.size()), 64'd5);
    check("t2_latency", 64'(getC(0) - issueCyc), 64'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_data%0d", i), 64'(getD(i)), 64'(exp2[i]));
      check($sformatf("t2_tag%0d", i), 64'(getT(i)), 64'(i + 1));
      check($sformatf("t2_cycle%0d", i), 64'(getC(i) - getC(0)), 64'(i));
    end

    // Backpressure: out_ready low for cycles 7..9, while op with tag 2 sits at the output
    clearQ();
    idx = 0;
    readyBad = 0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 7 && c < 10);
      if (idx < 8) drive(SHIFT_SLL, 32'(idx), 32'd1, 4'(idx));
      else in_valid = 1'b0;
      @(negedge clk);
      if (in_ready !== !(c >= 7 && c < 10)) readyBad++;
      if (c >= 7 && c < 10) begin
        check($sformatf("t3_hold_valid_c%0d", c), 64'(out_valid), 64'd1);
        check($sformatf("t3_hold_tag_c%0d", c), 64'(out_tag), 64'd2);
        check($sformatf("t3_hold_data_c%0d", c), 64'(out_data), 64'd4);
      end
      acc = in_valid && in_ready;
      step();
      if (acc) idx++;
    end
    out_ready = 1'b1;
    check("t3_in_ready_pattern", 64'(readyBad), 64'd0);
    check("t3_count", 64'(qData.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_tag%0d", i), 64'(getT(i)), 64'(i));
      check($sformatf("t3_data%0d", i), 64'(getD(i)), 64'(2 * i));
    end

    // op=11: rotate when enabled, otherwise plain SRL with saturation
    clearQ();
    drive(SHIFT_ROR, 32'hE2641233, 32'd4, 4'd6);    step();
    drive(SHIFT_ROR, 32'hE2641233, 32'd1256, 4'd7); step();
    in_valid = 1'b0;
    repeat (8) step();
    check("t4_count", 64'(qData.size()), 64'd2);
`ifdef PIPELINED_SHIFT_ROTATE_EN
    check("t4_ror4", 64'(getD(0)), 64'h3E264123);
    check("t4_ror1256", 64'(getD(1)), 64'h33E26412);
`else
    check("t4_srl4", 64'(getD(0)), 64'h0E264123);
    check("t4_srl1256", 64'(getD(1)), 64'h00000000);
`endif
    check("t4_tag1", 64'(getT(1)), 64'd7);

    // Async reset with three ops in flight
    clearQ();
    drive(SHIFT_SLL, 32'h1, 32'd0, 4'd8);  step();
    drive(SHIFT_SLL, 32'h2, 32'd0, 4'd9);  step();
    drive(SHIFT_SLL, 32'h3, 32'd0, 4'd10); step();
    in_valid = 1'b0;
    step(); step();
    check("t5_pre_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("t5_async_valid", 64'(out_valid), 64'd0);
    check("t5_async_data", 64'(out_data), 64'd0);
    check("t5_async_ready", 64'(in_ready), 64'd1);
    step(); step();
    rst = 1'b0;
    repeat (8) step();
    check("t5_no_stale", 64'(qData.size()), 64'd0);
    clearQ();
    drive(SHIFT_SRA, 32'h80000000, 32'd4, 4'd11);
    issueCyc = cyc;
    step();
    in_valid = 1'b0;
    repeat (8) step();
    check("t5_count", 64'(qData.size()), 64'd1);
    check("t5_data", 64'(getD(0)), 64'hF8000000);
    check("t5_tag", 64'(getT(0)), 64'd11);
    check("t5_latency", 64'(getC(0) - issueCyc), 64'd5);

    // Boundary amounts
    clearQ();
    exp6[0] = 32'h80000000; exp6[1] = 32'hFFFFFFFF; exp6[2] = 32'hFFFFFFFF; exp6[3] = 32'h80000000;
    drive(SHIFT_SRA, 32'h80000000, 32'd0, 4'd12);  step();
    drive(SHIFT_SRA, 32'h80000000, 32'd31, 4'd13); step();
    drive(SHIFT_SRA, 32'h80000000, 32'd32, 4'd14); step();
    drive(SHIFT_SLL, 32'h00000001, 32'd31, 4'd15); step();
    in_valid = 1'b0;
    repeat (10) step();
    check("t6_count", 64'(qData.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t6_data%0d", i), 64'(getD(i)), 64'(exp6[i]));
      check($sformatf("t6_tag%0d", i), 64'(getT(i)), 64'(12 + i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
